uart_boot_loader: RTL and testbench

- Bus-initiator FSM that drives the CPU-side data-memory port of the RAM/serial controller.
- Boots a program image received over the serial port:
  - polls the serial status register;
  - pops bytes from the serial data register;
  - assembles little-endian words;
  - writes them into base/ext RAM.
- Sits beside the MEM stage; the top-level mux hands it the memory port while busy=1.

---
 rtl/uart_boot_loader.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//
// Purpose: bus-initiator that boots a program image received over the serial
// port into base/ext RAM. It polls the serial status register, pops bytes from
// the serial data register, assembles little-endian words and writes them to
// RAM. The top-level mux gives it the CPU data-memory port while busy=1.
//
// Image on the wire (little-endian): LEN (words, 4 bytes), DST (byte address,
// 4 bytes), then LEN x 4 data bytes.
//
// Optional feature: define BOOT_CHECKSUM_ECHO_EN to keep an 8-bit XOR checksum
// of the data bytes and transmit it back over the serial port before done.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   start          one-cycle request to begin loading (ignored while busy)
//   mem_addr_o     bus address (registered)
//   mem_data_o     bus write data (registered)
//   mem_we_o       bus write enable (registered)
//   mem_sel_o      bus byte select (registered)
//   mem_data_i     bus read data, valid in the same cycle as the address
//   busy           loader owns the memory port
//   done           one-cycle pulse on successful completion
//   err            sticky error flag, cleared by the next accepted start
//   words_written  words written in the current or last load
module uart_boot_loader #(
  parameter int unsigned MAX_WORDS    = 262144,
  parameter logic [31:0] POLL_TIMEOUT = 32'd60200000,
  parameter logic [31:0] IDLE_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  input  logic [31:0] mem_data_i,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] words_written
);

  localparam logic [31:0] SERIAL_STATE = 32'hBFD003FC;
  localparam logic [31:0] SERIAL_DATA  = 32'hBFD003F8;
  localparam logic [31:0] RAM_BASE     = 32'h80000000;
  localparam logic [31:0] RAM_END      = 32'h80800000;
  localparam logic [31:0] MAX_WORDS_W  = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef BOOT_CHECKSUM_ECHO_EN
    ,
    S_ECHO_POLL,
    S_ECHO
`endif
  } state_t;

  typedef enum logic [1:0] {
    PH_LEN,
    PH_ADDR,
    PH_DATA
  } phase_t;

  // State entered once the image body is complete.
`ifdef BOOT_CHECKSUM_ECHO_EN
  localparam state_t S_FINISH = S_ECHO_POLL;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] words_written_q, words_written_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
`ifdef BOOT_CHECKSUM_ECHO_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // Word completed by the byte currently on the bus (valid in READ).
  logic [31:0] word;
  // Byte address one past the image; 34 bits so it cannot wrap.
  logic [33:0] end_addr;
  // Only the low byte of the read data carries information.
  logic        unused_rdata;

  assign word         = {mem_data_i[7:0], shreg_q[31:8]};
  assign end_addr     = {2'b00, word} + {remaining_q, 2'b00};
  assign unused_rdata = ^mem_data_i[31:8];

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    byte_cnt_d      = byte_cnt_q;
    timer_d         = timer_q;
    shreg_d         = shreg_q;
    remaining_d     = remaining_q;
    dst_d           = dst_q;
    words_written_d = words_written_q;
    busy_d          = busy_q;
    err_d           = err_q;
`ifdef BOOT_CHECKSUM_ECHO_EN
    csum_d          = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d          = 1'b1;
          err_d           = 1'b0;
          words_written_d = 32'd0;
          phase_d         = PH_LEN;
          byte_cnt_d      = 2'd0;
          timer_d         = 32'd0;
`ifdef BOOT_CHECKSUM_ECHO_EN
          csum_d          = 8'h00;
`endif
          state_d         = S_POLL;
        end
      end

      S_POLL: begin
        if (mem_data_i[1]) begin
          timer_d = 32'd0;
          state_d = S_READ;
        end else if (timer_q == POLL_TIMEOUT - 32'd1) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      S_READ: begin
        shreg_d    = word;
        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_ECHO_EN
        if (phase_q == PH_DATA) begin
          csum_d = csum_q ^ mem_data_i[7:0];
        end
`endif
        state_d = S_POLL;
        if (byte_cnt_q == 2'd3) begin
          case (phase_q)
            PH_LEN: begin
              if (word > MAX_WORDS_W) begin
                state_d = S_ERR;
              end else begin
                remaining_d = word;
                phase_d     = PH_ADDR;
              end
            end
            PH_ADDR: begin
              if ((word[1:0] != 2'b00) || (word < RAM_BASE) ||
                  (end_addr > {2'b00, RAM_END})) begin
                state_d = S_ERR;
              end else begin
                dst_d = word;
                if (remaining_q == 32'd0) begin
                  state_d = S_FINISH;
                end else begin
                  phase_d = PH_DATA;
                end
              end
            end
            default: begin
              state_d = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        dst_d           = dst_q + 32'd4;
        remaining_d     = remaining_q - 32'd1;
        words_written_d = words_written_q + 32'd1;
        state_d         = (remaining_q == 32'd1) ? S_FINISH : S_POLL;
      end

`ifdef BOOT_CHECKSUM_ECHO_EN
      S_ECHO_POLL: begin
        if (mem_data_i[0]) begin
          timer_d = 32'd0;
          state_d = S_ECHO;
        end else if (timer_q == POLL_TIMEOUT - 32'd1) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      S_ECHO: begin
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // done and the bus are registered, so they are derived from the state
    // being entered: the outputs then line up with state_q on the next cycle.
    done_d     = (state_d == S_DONE);
    mem_addr_d = IDLE_ADDR;
    mem_data_d = 32'd0;
    mem_we_d   = 1'b0;
    mem_sel_d  = 4'b0000;
    case (state_d)
      S_POLL: begin
        mem_addr_d = SERIAL_STATE;
      end
      S_READ: begin
        mem_addr_d = SERIAL_DATA;
        mem_sel_d  = 4'b0001;
      end
      S_WRITE: begin
        // dst only advances when leaving WRITE, so dst_q is the target here.
        mem_addr_d = dst_q;
        mem_data_d = shreg_d;
        mem_we_d   = 1'b1;
        mem_sel_d  = 4'b1111;
      end
`ifdef BOOT_CHECKSUM_ECHO_EN
      S_ECHO_POLL: begin
        mem_addr_d = SERIAL_STATE;
      end
      S_ECHO: begin
        mem_addr_d = SERIAL_DATA;
        mem_data_d = {24'h000000, csum_d};
        mem_we_d   = 1'b1;
        mem_sel_d  = 4'b0001;
      end
`endif
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      phase_q         <= PH_LEN;
      byte_cnt_q      <= 2'd0;
      timer_q         <= 32'd0;
      shreg_q         <= 32'd0;
      remaining_q     <= 32'd0;
      dst_q           <= 32'd0;
      words_written_q <= 32'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      mem_addr_q      <= IDLE_ADDR;
      mem_data_q      <= 32'd0;
      mem_we_q        <= 1'b0;
      mem_sel_q       <= 4'b0000;
`ifdef BOOT_CHECKSUM_ECHO_EN
      csum_q          <= 8'h00;
`endif
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      byte_cnt_q      <= byte_cnt_d;
      timer_q         <= timer_d;
      shreg_q         <= shreg_d;
      remaining_q     <= remaining_d;
      dst_q           <= dst_d;
      words_written_q <= words_written_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      mem_we_q        <= mem_we_d;
      mem_sel_q       <= mem_sel_d;
`ifdef BOOT_CHECKSUM_ECHO_EN
      csum_q          <= csum_d;
`endif
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;
  assign mem_we_o      = mem_we_q;
  assign mem_sel_o     = mem_sel_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: a serial-port model feeds images byte by
// byte (with random RX-available gaps); expected RAM writes are derived from
// the image rules and checked on every bus write cycle.
module tb_uart_boot_loader;

  localparam int          MAXW   = 16;
  localparam logic [31:0] TMO    = 32'd40;
  localparam logic [31:0] SER_ST = 32'hBFD003FC;
  localparam logic [31:0] SER_DT = 32'hBFD003F8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_data_i;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] words_written;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .MAX_WORDS   (MAXW),
    .POLL_TIMEOUT(TMO),
    .IDLE_ADDR   (32'h00000000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_we_o     (mem_we_o),
    .mem_sel_o    (mem_sel_o),
    .mem_data_i   (mem_data_i),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_written(words_written)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- serial port model ----------------
  logic [7:0] rx_mem [0:1023];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic       stall  = 1'b0;
  logic       rx_avail;

  assign rx_avail = (rd_ptr != wr_ptr) && !stall;

  always_comb begin
    mem_data_i = 32'h5A5A5A5A;
    if (mem_addr_o == SER_ST)
      mem_data_i = {24'h5A5A5A, 6'h00, rx_avail, 1'b1};
    else if (mem_addr_o == SER_DT)
      mem_data_i = {24'hA5A5A5, rx_mem[rd_ptr % 1024]};
  end

  // A read of the data register pops one byte per cycle it is presented.
  always @(posedge clk) begin
    if (mem_addr_o == SER_DT && !mem_we_o && rd_ptr != wr_ptr)
      rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clk) stall <= ($urandom_range(0, 3) == 0);

  // ---------------- reference expectations ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         wr_log[$];
  wr_t         mon_e;
  wr_t         mon_a;
  int          done_cnt = 0;
  logic [31:0] fixed_words[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare process: every bus cycle with we=1 must be the next expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (mem_we_o) begin
        mon_a.addr = mem_addr_o;
        mon_a.data = mem_data_o;
        mon_a.sel  = mem_sel_o;
        wr_log.push_back(mon_a);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual=%h@%h sel=%b required=none",
                   mem_data_o, mem_addr_o, mem_sel_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_addr_o !== mon_e.addr || mem_data_o !== mon_e.data || mem_sel_o !== mon_e.sel) begin
            errors++;
            $display("FAIL write actual=%h@%h sel=%b required=%h@%h sel=%b",
                     mem_data_o, mem_addr_o, mem_sel_o, mon_e.data, mon_e.addr, mon_e.sel);
          end
        end
      end else if (mem_sel_o != 4'b0000 && !(mem_addr_o == SER_DT && mem_sel_o == 4'b0001)) begin
        checks++;
        errors++;
        $display("FAIL bus_read actual=%h sel=%b required=serial data read", mem_addr_o, mem_sel_o);
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      rx_mem[wr_ptr % 1024] = w[8*b +: 8];
      wr_ptr++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) until the loader has released the port after done or err.
  task automatic wait_end(input int budget, input int d0, input bit poke, output bit fin);
    fin = 1'b0;
    for (int i = 0; i < budget && !fin; i++) begin
      @(negedge clk);
      start = (poke && i == 10 && busy) ? 1'b1 : 1'b0;
      if (!busy && start == 1'b0 && (done_cnt != d0 || err)) fin = 1'b1;
    end
    start = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL wait_end actual=timeout required=done or err");
    end
  endtask

  // Sends one image and checks the outcome predicted from the image rules.
  task automatic run_image(input logic [31:0] len, input logic [31:0] dst,
                           input bit poke, input bit use_fixed);
    bit          len_ok, ok, fin;
    longint      end_b;
    logic [31:0] w;
    logic [7:0]  cs;
    int          d0;
    int          nb;
    len_ok = (longint'(len) <= longint'(MAXW));
    end_b  = longint'(dst) + 4 * longint'(len);
    ok     = len_ok && (dst[1:0] == 2'b00) && (dst >= 32'h80000000) &&
             (end_b <= 64'h80800000);
    cs     = 8'h00;
    wr_log.delete();
    push_word(len, 4);
    nb = 4;
    if (len_ok) begin
      push_word(dst, 4);
      nb += 4;
    end
    if (ok) begin
      for (int i = 0; i < int'(len); i++) begin
        w = use_fixed ? fixed_words[i] : $urandom;
        push_word(w, 4);
        nb += 4;
        cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        exp_q.push_back('{addr: dst + 32'(4 * i), data: w, sel: 4'b1111});
      end
`ifdef BOOT_CHECKSUM_ECHO_EN
      exp_q.push_back('{addr: SER_DT, data: {24'h0, cs}, sel: 4'b0001});
`endif
    end
    d0 = done_cnt;
    pulse_start();
    wait_end(20 * nb + 200, d0, poke, fin);
    chk("done_pulses", 32'(done_cnt - d0), ok ? 32'd1 : 32'd0);
    chk("err", {31'd0, err}, {31'd0, !ok});
    chk("busy", {31'd0, busy}, 32'd0);
    chk("words_written", words_written, ok ? len : 32'd0);
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
    $display("IMG len=%0d dst=%h ok=%0d done=%0d err=%0d words_written=%0d",
             len, dst, ok, done_cnt - d0, err, words_written);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_data"}, mem_data_o, 32'h0);
    chk({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
    chk({tag, "_sel"}, {28'd0, mem_sel_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_ww"}, words_written, 32'd0);
  endtask

  initial begin
    bit          fin;
    int          d0;
    logic [31:0] len, dst, w;
    int          mode;

    // Reset held 3 cycles with start also high: rst wins.
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk_reset_outputs("reset");
    @(negedge clk);
    chk("reset_then_idle_busy", {31'd0, busy}, 32'd0);
    $display("RESET checked");

    // Example image from the test plan.
    fixed_words = '{32'h12345678, 32'hDEADBEEF};
    run_image(32'd2, 32'h80001000, 1'b0, 1'b1);
    chk("ex_wr0_addr", wr_log.size() > 0 ? wr_log[0].addr : 32'hX, 32'h80001000);
    chk("ex_wr0_data", wr_log.size() > 0 ? wr_log[0].data : 32'hX, 32'h12345678);
    chk("ex_wr1_addr", wr_log.size() > 1 ? wr_log[1].addr : 32'hX, 32'h80001004);
    chk("ex_wr1_data", wr_log.size() > 1 ? wr_log[1].data : 32'hX, 32'hDEADBEEF);
    chk("ex_ww", words_written, 32'd2);

    // Empty image: no RAM write.
    run_image(32'd0, 32'h80400000, 1'b0, 1'b0);
`ifdef BOOT_CHECKSUM_ECHO_EN
    chk("len0_bus_writes", 32'(wr_log.size()), 32'd1);
`else
    chk("len0_bus_writes", 32'(wr_log.size()), 32'd0);
`endif

    // Header errors and range boundaries.
    run_image(32'd1, 32'h80000002, 1'b0, 1'b0);
    chk("unaligned_no_write", 32'(wr_log.size()), 32'd0);
    run_image(32'd1, 32'h7FFFFFFC, 1'b0, 1'b0);
    chk("lowdst_no_write", 32'(wr_log.size()), 32'd0);
    run_image(32'd3, 32'h807FFFF8, 1'b0, 1'b0);
    run_image(32'd2, 32'h807FFFF8, 1'b0, 1'b0);
    run_image(32'(MAXW + 1), 32'h80000000, 1'b0, 1'b0);
    run_image(32'(MAXW), 32'h80000100, 1'b1, 1'b0);

    // Stall mid-image: one word arrives, then two bytes, then nothing.
    wr_log.delete();
    push_word(32'd3, 4);
    push_word(32'h80002000, 4);
    w = $urandom;
    exp_q.push_back('{addr: 32'h80002000, data: w, sel: 4'b1111});
    push_word(w, 4);
    push_word($urandom, 2);
    d0 = done_cnt;
    pulse_start();
    wait_end(600, d0, 1'b0, fin);
    chk("stall_err", {31'd0, err}, 32'd1);
    chk("stall_done", 32'(done_cnt - d0), 32'd0);
    chk("stall_ww", words_written, 32'd1);
    chk("stall_pending", 32'(exp_q.size()), 32'd0);
    $display("STALL err=%0d words_written=%0d", err, words_written);
    run_image(32'd3, 32'h80003000, 1'b0, 1'b0);

    // Reset after 5 data bytes.
    push_word(32'd2, 4);
    push_word(32'h80004000, 4);
    w = $urandom;
    exp_q.push_back('{addr: 32'h80004000, data: w, sel: 4'b1111});
    push_word(w, 4);
    push_word($urandom, 1);
    pulse_start();
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (rd_ptr == wr_ptr && exp_q.size() == 0) fin = 1'b1;
    end
    chk("rst_prefix_consumed", {31'd0, fin}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    chk("midrst_idle_we", {31'd0, mem_we_o}, 32'd0);
    $display("MIDRST checked");
    run_image(32'd4, 32'h80005000, 1'b0, 1'b0);

    // Randomised images.
    for (int n = 0; n < 12; n++) begin
      len  = $urandom_range(0, 6);
      mode = $urandom_range(0, 5);
      dst  = 32'h80000000 + ($urandom_range(0, 32'h1FFFFF) << 2);
      if (mode == 0) dst = dst | 32'($urandom_range(1, 3));
      if (mode == 1) dst = $urandom_range(0, 32'h7FFFFFF) << 2;
      if (mode == 2) dst = 32'h80800000 - 32'($urandom_range(0, 8) * 4);
      run_image(len, dst, n[0], 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
